// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width needed to count WIDTH shift cycles.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder composed of two half adders; the two partial carries are ORed.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder_cell u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder_cell u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder_cell.sv
// One-bit half adder: the primitive the full-adder cell is built from.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, a carry flop and a bit counter
// produce one sum bit per clock; operands and results move over valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_narrow
            assign sum_shifted = fa_s;
        end else begin : g_sum_wide
            assign sum_shifted = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit  = (cnt == LAST);

    // Handshake flags decode straight from the state register, never from out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, shift WIDTH bits, then hold the result until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, shift one bit per cycle, latch the result on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    sum_sh <= sum_shifted;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= sum_shifted;
                        cout_q <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances driven by
// directed vector tables, hand-written corner sequences and a random sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] in_a1;
    logic [0:0] in_b1;
    logic       in_cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] out_sum1;
    logic       out_cout1;
    logic       busy1;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .in_cin    (in_cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_cout  (out_cout1),
        .busy      (busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer one operand set to the WIDTH=8 instance; lat counts edges from accept to out_valid.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        int guard;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    // Same for the WIDTH=1 instance.
    task automatic applyStimulus1(input logic a, input logic b, input logic c, output int lat);
        int guard;
        guard     = 0;
        in_a1     = a;
        in_b1     = b;
        in_cin1   = c;
        in_valid1 = 1'b1;
        while (!in_ready1 && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 50) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp9;
        logic [1:0] exp2;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_a1      = '0;
        in_b1      = '0;
        in_cin1    = 1'b0;
        out_ready1 = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state of both instances.
        checkOutput("rst_in_ready",  in_ready,  1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum",   out_sum,   0);
        checkOutput("rst_out_cout",  out_cout,  0);
        checkOutput("rst_busy",      busy,      0);
        checkOutput("rst1_in_ready", in_ready1, 1);
        checkOutput("rst1_out_valid", out_valid1, 0);

        // Directed vector table, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, 8);
            checkOutput($sformatf("v%0d_sum", i), out_sum, vecs[i].sum);
            checkOutput($sformatf("v%0d_cout", i), out_cout, vecs[i].cout);
            checkOutput($sformatf("v%0d_busy", i), busy, 1);
            step();
            checkOutput($sformatf("v%0d_idle_ready", i), in_ready, 1);
            checkOutput($sformatf("v%0d_idle_valid", i), out_valid, 0);
            checkOutput($sformatf("v%0d_retained_sum", i), out_sum, vecs[i].sum);
        end

        // Backpressure: result held stable while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h0F, 1'b0, lat);
        checkOutput("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_valid",    out_valid, 1);
            checkOutput("bp_in_ready", in_ready,  0);
            checkOutput("bp_sum",      out_sum,   8'h4B);
            checkOutput("bp_cout",     out_cout,  0);
        end
        out_ready = 1'b1;
        step();
        checkOutput("bp_release_in_ready", in_ready, 1);
        checkOutput("bp_release_valid",    out_valid, 0);

        // in_valid pulsed mid-SHIFT must be ignored.
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_a     = 8'h55;
        in_b     = 8'h00;
        in_valid = 1'b1;
        checkOutput("mid_in_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        lat = 3;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        checkOutput("mid_latency", lat, 8);
        checkOutput("mid_sum",     out_sum, 8'h46);
        checkOutput("mid_cout",    out_cout, 0);
        step();
        for (int i = 0; i < 10; i++) step();
        checkOutput("mid_no_ghost_op", out_valid, 0);

        // Reset during SHIFT aborts and clears the result.
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        checkOutput("abort_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_in_ready",  in_ready,  1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_out_sum",   out_sum,   0);
        checkOutput("abort_out_cout",  out_cout,  0);
        checkOutput("abort_busy",      busy,      0);
        applyStimulus(8'h80, 8'h80, 1'b0, lat);
        checkOutput("after_abort_latency", lat, 8);
        checkOutput("after_abort_sum",  out_sum,  8'h00);
        checkOutput("after_abort_cout", out_cout, 1);
        step();

        // Random WIDTH=8 operations against an integer-add model.
        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            applyStimulus(ra, rb, rc, lat);
            checkOutput("rand8_result", {out_cout, out_sum}, exp9);
            step();
        end

        // WIDTH=1 instance: single shift cycle.
        applyStimulus1(1'b1, 1'b1, 1'b1, lat);
        checkOutput("w1_latency", lat, 1);
        checkOutput("w1_sum",     out_sum1,  1);
        checkOutput("w1_cout",    out_cout1, 1);
        step();
        checkOutput("w1_idle_ready", in_ready1, 1);

        // WIDTH=1 random back-to-back sweep.
        for (int i = 0; i < 500; i++) begin
            ra   = 8'($urandom_range(0, 1));
            rb   = 8'($urandom_range(0, 1));
            rc   = 1'($urandom);
            exp2 = {1'b0, ra[0]} + {1'b0, rb[0]} + {1'b0, rc};
            applyStimulus1(ra[0], rb[0], rc, lat);
            checkOutput("rand1_result", {lat[5:0] == 6'd1, out_cout1, out_sum1}, {1'b1, exp2});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
